// File: rtl/lut_search_pkg.sv
// rtl/lut_search_pkg.sv - shared FSM encodings and sizing helper for the reverse-lookup block
// Contents:
//   ST_IDLE/ST_SCAN/ST_DONE : FSM state encodings
//   state_t                 : FSM state type built from those encodings
//   idx_width()             : index width, never narrower than one bit
package lut_search_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SCAN = ST_SCAN,
        DONE = ST_DONE
    } state_t;

    // A single-entry table still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_rev_search_if.sv
// rtl/lut_rev_search_if.sv - table write, query and response bundle for lut_rev_search
// Signals:
//   wr_en/wr_idx/wr_key/wr_data : table write port
//   req_valid/req_ready/req_data : query handshake
//   rsp_valid/rsp_ready/rsp_hit/rsp_key/rsp_idx : response handshake
// Modports: master drives writes and queries, slave is the lookup block.
interface lut_rev_search_if #(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 4
) ();
    localparam int IDX_W = lut_search_pkg::idx_width(NR_KEY);

    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [KEY_LEN-1:0]  wr_key;
    logic [DATA_LEN-1:0] wr_data;
    logic                req_valid;
    logic                req_ready;
    logic [DATA_LEN-1:0] req_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_hit;
    logic [KEY_LEN-1:0]  rsp_key;
    logic [IDX_W-1:0]    rsp_idx;

    modport master (
        output wr_en, wr_idx, wr_key, wr_data, req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_key, rsp_idx
    );

    modport slave (
        input  wr_en, wr_idx, wr_key, wr_data, req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_key, rsp_idx
    );
endinterface

// File: rtl/lut_table.sv
// rtl/lut_table.sv - key/data table storage with a single write port
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   wr_en_i/wr_idx_i/wr_key_i/wr_data_i : write strobe, entry index, key, data
//   valid_o/key_o/data_o           : per-entry contents, flattened per entry
module lut_table #(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 4,
    parameter int IDX_W    = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en_i,
    input  logic [IDX_W-1:0]                   wr_idx_i,
    input  logic [KEY_LEN-1:0]                 wr_key_i,
    input  logic [DATA_LEN-1:0]                wr_data_i,
    output logic [NR_KEY-1:0]                  valid_o,
    output logic [NR_KEY-1:0][KEY_LEN-1:0]     key_o,
    output logic [NR_KEY-1:0][DATA_LEN-1:0]    data_o
);
    logic [NR_KEY-1:0]               valid_q;
    logic [NR_KEY-1:0][KEY_LEN-1:0]  key_q;
    logic [NR_KEY-1:0][DATA_LEN-1:0] data_q;

    // Only indices 0..NR_KEY-1 are decoded, so an out-of-range write hits no entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            key_q   <= '0;
            data_q  <= '0;
        end else begin
            for (int k = 0; k < NR_KEY; k++) begin
                if (wr_en_i && (wr_idx_i == IDX_W'(k))) begin
                    valid_q[k] <= 1'b1;
                    key_q[k]   <= wr_key_i;
                    data_q[k]  <= wr_data_i;
                end
            end
        end
    end

    assign valid_o = valid_q;
    assign key_o   = key_q;
    assign data_o  = data_q;
endmodule

// File: rtl/lut_rev_search.sv
// rtl/lut_rev_search.sv - data-to-key reverse lookup over a key/data table, one entry per cycle
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : lut_rev_search_if.slave (table writes, query in, response out)
// A query is scanned from entry 0 upward; the first valid entry whose data
// equals the query wins. The response is held until rsp_ready.
module lut_rev_search
    import lut_search_pkg::*;
#(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 4,
    localparam int IDX_W   = idx_width(NR_KEY)
) (
    input  logic           clk,
    input  logic           rst,
    lut_rev_search_if.slave bus
);
    logic [NR_KEY-1:0]               tbl_valid;
    logic [NR_KEY-1:0][KEY_LEN-1:0]  tbl_key;
    logic [NR_KEY-1:0][DATA_LEN-1:0] tbl_data;

    lut_table #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN),
        .IDX_W    (IDX_W)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (bus.wr_en),
        .wr_idx_i  (bus.wr_idx),
        .wr_key_i  (bus.wr_key),
        .wr_data_i (bus.wr_data),
        .valid_o   (tbl_valid),
        .key_o     (tbl_key),
        .data_o    (tbl_data)
    );

    state_t              state_q;
    logic [IDX_W-1:0]    scan_q;
    logic [DATA_LEN-1:0] query_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic                rsp_hit_q;
    logic [KEY_LEN-1:0]  rsp_key_q;
    logic [IDX_W-1:0]    rsp_idx_q;

    logic match;
    logic last;

    // The compare sees the table as it stands this cycle; a write landing on
    // the same edge only becomes visible to later entries of the scan.
    assign match = tbl_valid[scan_q] && (tbl_data[scan_q] == query_q);
    assign last  = (scan_q == IDX_W'(NR_KEY - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            scan_q      <= '0;
            query_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_key_q   <= '0;
            rsp_idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        query_q     <= bus.req_data;
                        scan_q      <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    if (match) begin
                        rsp_hit_q   <= 1'b1;
                        rsp_key_q   <= tbl_key[scan_q];
                        rsp_idx_q   <= scan_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (last) begin
                        rsp_hit_q   <= 1'b0;
                        rsp_key_q   <= '0;
                        rsp_idx_q   <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        scan_q <= scan_q + 1'b1;
                    end
                end
                DONE: begin
                    // req_valid is not looked at here: the next query can only
                    // be taken once IDLE has been re-entered.
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_hit_q   <= 1'b0;
                        rsp_key_q   <= '0;
                        rsp_idx_q   <= '0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_key   = rsp_key_q;
    assign bus.rsp_idx   = rsp_idx_q;
endmodule

// File: tb/tb_lut_rev_search.sv
// tb/tb_lut_rev_search.sv - directed self-checking bench for lut_rev_search (4 entries, 2-bit key, 4-bit data)
module tb_lut_rev_search;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   lat;

    always #5 clk = ~clk;

    lut_rev_search_if #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(4)) bus ();

    lut_rev_search #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [1:0] idx, input logic [1:0] key, input logic [3:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_idx  = idx;
        bus.wr_key  = key;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic start_q(input logic [3:0] data);
        bus.req_valid = 1'b1;
        bus.req_data  = data;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus.rsp_valid && n < 16) begin
            tick();
            n++;
        end
    endtask

    task automatic check_rsp(input string tag, input int n, input int exp_lat,
                             input logic hit, input logic [1:0] key, input logic [1:0] idx);
        chk({tag, ".lat"}, n, exp_lat);
        chk({tag, ".valid"}, bus.rsp_valid, 1'b1);
        chk({tag, ".hit"}, bus.rsp_hit, hit);
        chk({tag, ".key"}, bus.rsp_key, key);
        chk({tag, ".idx"}, bus.rsp_idx, idx);
    endtask

    task automatic ack(input string tag);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk({tag, ".ack_valid"}, bus.rsp_valid, 1'b0);
        chk({tag, ".ack_ready"}, bus.req_ready, 1'b1);
    endtask

    task automatic query(input string tag, input logic [3:0] data, input int exp_lat,
                         input logic hit, input logic [1:0] key, input logic [1:0] idx);
        int n;
        start_q(data);
        wait_rsp(n);
        check_rsp(tag, n, exp_lat, hit, key, idx);
        ack(tag);
    endtask

    initial begin
        bus.wr_en     = 1'b0;
        bus.wr_idx    = '0;
        bus.wr_key    = '0;
        bus.wr_data   = '0;
        bus.req_valid = 1'b0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;

        tick();
        tick();
        chk("rst.req_ready", bus.req_ready, 1'b1);
        chk("rst.rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst.rsp_hit", bus.rsp_hit, 1'b0);
        chk("rst.rsp_key", bus.rsp_key, 2'd0);
        chk("rst.rsp_idx", bus.rsp_idx, 2'd0);
        rst = 1'b0;
        tick();

        // Entries reset with data 0 but invalid, so querying 0 misses.
        query("empty0", 4'h0, 4, 1'b0, 2'd0, 2'd0);

        write_entry(2'd0, 2'd3, 4'h5);
        write_entry(2'd1, 2'd2, 4'hA);
        write_entry(2'd2, 2'd1, 4'h5);
        write_entry(2'd3, 2'd0, 4'hF);

        query("q5", 4'h5, 1, 1'b1, 2'd3, 2'd0);
        query("qF", 4'hF, 4, 1'b1, 2'd0, 2'd3);
        query("q7", 4'h7, 4, 1'b0, 2'd0, 2'd0);
        query("qA", 4'hA, 2, 1'b1, 2'd2, 2'd1);

        // Response held under back-pressure while a new query is offered.
        start_q(4'hA);
        wait_rsp(lat);
        check_rsp("hold", lat, 2, 1'b1, 2'd2, 2'd1);
        bus.req_valid = 1'b1;
        bus.req_data  = 4'h5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold.valid", bus.rsp_valid, 1'b1);
            chk("hold.req_ready", bus.req_ready, 1'b0);
            chk("hold.key", bus.rsp_key, 2'd2);
            chk("hold.idx", bus.rsp_idx, 2'd1);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("hold.hs_valid", bus.rsp_valid, 1'b0);
        chk("hold.hs_req_ready", bus.req_ready, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        chk("hold.accept", bus.req_ready, 1'b0);
        wait_rsp(lat);
        check_rsp("hold.next", lat, 1, 1'b1, 2'd3, 2'd0);
        ack("hold.next");

        // Write during the first scan cycle becomes visible to later entries.
        start_q(4'h9);
        bus.wr_en   = 1'b1;
        bus.wr_idx  = 2'd2;
        bus.wr_key  = 2'd1;
        bus.wr_data = 4'h9;
        tick();
        bus.wr_en   = 1'b0;
        wait_rsp(lat);
        check_rsp("wrscan", lat + 1, 3, 1'b1, 2'd1, 2'd2);
        ack("wrscan");

        // Reset in the second scan cycle drops the query and clears the table.
        start_q(4'hF);
        tick();
        rst = 1'b1;
        #1;
        chk("rstscan.req_ready", bus.req_ready, 1'b1);
        chk("rstscan.rsp_valid", bus.rsp_valid, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rstscan.no_rsp", bus.rsp_valid, 1'b0);
        end
        query("rstscan.q5", 4'h5, 4, 1'b0, 2'd0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
